// File: rtl/fire_gold_game_ctrl_param.sv
// fire_gold_game_ctrl_param
//   Fire-dodge / gold-catch game controller for a CELLS-cell board. A step
//   timer on the system clock paces the game; each step redraws the fire
//   pattern from a 16-bit Galois LFSR and alternately places/clears one gold.
//   Touching an un-hit fire cell costs one life per cell per step; touching
//   the gold scores and raises the level, which shortens the step period.
// Ports
//   i_clk, i_rst        clock, async active-high reset
//   i_start, i_pause    levels; rising edges start/leave-finish and toggle pause
//   i_super             player invulnerable while high
//   i_box[CELLS]        cells occupied by the player
//   o_game_state        00 IDLE, 01 PLAY, 10 FINISH, 11 PAUSE
//   o_fire_state        fire pattern with this step's hit cells removed
//   o_gold_state        one-hot gold cell, or 0 (also 0 once caught)
//   o_hit_bitmap        cells that have already damaged this step
//   o_life/o_score/o_level, o_step_pulse, o_win
module fire_gold_game_ctrl_param #(
  parameter int              CELLS       = 9,
  parameter int              LIFE_MAX    = 5,
  parameter int              SCORE_MAX   = 3,
  parameter int              FIRE_MAX    = 4,
  parameter int              BASE_PERIOD = 2**24,
  parameter int              MIN_PERIOD  = 2**21,
  parameter int              LEVEL_MAX   = 3,
  parameter logic [15:0]     LFSR_SEED   = 16'hACE1,
  parameter logic [CELLS-1:0] FIRE_INIT  = 9'b101000100
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic                             i_start,
  input  logic                             i_pause,
  input  logic                             i_super,
  input  logic [CELLS-1:0]                 i_box,
  output logic [1:0]                       o_game_state,
  output logic [CELLS-1:0]                 o_fire_state,
  output logic [CELLS-1:0]                 o_gold_state,
  output logic [CELLS-1:0]                 o_hit_bitmap,
  output logic [$clog2(LIFE_MAX+1)-1:0]    o_life,
  output logic [$clog2(SCORE_MAX+1)-1:0]   o_score,
  output logic [$clog2(LEVEL_MAX+1)-1:0]   o_level,
  output logic                             o_step_pulse,
  output logic                             o_win
);
  localparam int LW = $clog2(LIFE_MAX+1);
  localparam int SW = $clog2(SCORE_MAX+1);
  localparam int VW = $clog2(LEVEL_MAX+1);
  localparam int TW = $clog2(BASE_PERIOD+1);
  localparam int DW = $clog2(CELLS+1);
  localparam int CW = $clog2(CELLS);

  typedef enum logic [1:0] {S_IDLE = 2'b00, S_PLAY = 2'b01, S_FINISH = 2'b10, S_PAUSE = 2'b11} state_t;

  state_t            r_state, w_state_nx;
  logic              r_start_d, r_pause_d, r_caught;
  logic [LW-1:0]     r_life;
  logic [SW-1:0]     r_score;
  logic [VW-1:0]     r_level;
  logic [15:0]       r_lfsr;
  logic [TW-1:0]     r_timer, r_period;
  logic [CELLS-1:0]  r_fire, r_gold, r_hit;

  logic              w_start_rise, w_pause_rise, w_play, w_step, w_catch, w_to_idle;
  logic [15:0]       w_lfsr_nx;
  logic [CELLS-1:0]  w_fire_nx, w_gold_nx, w_gold_vis, w_dmg;
  logic [DW-1:0]     w_d;

  function automatic logic [TW-1:0] period_of(input logic [VW-1:0] lvl);
    int p;
    p = BASE_PERIOD >> lvl;
    if (p < MIN_PERIOD) p = MIN_PERIOD;
    return TW'(p);
  endfunction

  assign w_start_rise = i_start & ~r_start_d;
  assign w_pause_rise = i_pause & ~r_pause_d;
  assign w_play       = (r_state == S_PLAY);
  // >= rather than == keeps the timer safe even if the period ever shrank under it
  assign w_step       = w_play && (r_timer >= r_period - TW'(1));
  assign w_to_idle    = (r_state == S_FINISH) && w_start_rise;
  assign w_lfsr_nx    = {1'b0, r_lfsr[15:1]} ^ ({16{r_lfsr[0]}} & 16'hB400);
  assign w_gold_vis   = r_caught ? '0 : r_gold;
  assign w_dmg        = i_box & r_fire & ~r_hit & ~w_gold_vis;
  assign w_d          = DW'($countones(w_dmg));
  assign w_catch      = w_play && (|(i_box & w_gold_vis));

  // New fire pattern: the lowest FIRE_MAX set bits of the advanced LFSR
  always_comb begin : p_fire
    int cnt;
    cnt = 0;
    w_fire_nx = '0;
    for (int i = 0; i < CELLS; i++) begin
      if (w_lfsr_nx[i] && cnt < FIRE_MAX) begin
        w_fire_nx[i] = 1'b1;
        cnt = cnt + 1;
      end
    end
  end

  // Gold toggles per step; when placed, take the first non-fire cell scanning
  // upward (with wrap) from lfsr[15:12] mod CELLS
  always_comb begin : p_gold
    int st;
    logic [CW-1:0] idx;
    logic found;
    w_gold_nx = '0;
    found = 1'b0;
    st = int'(w_lfsr_nx[15:12]) % CELLS;
    for (int i = 0; i < CELLS; i++) begin
      idx = CW'((st + i) % CELLS);
      if (!found && !w_fire_nx[idx]) begin
        w_gold_nx[idx] = 1'b1;
        found = 1'b1;
      end
    end
    if (r_gold != '0) w_gold_nx = '0;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE:   if (w_start_rise) w_state_nx = S_PLAY;
      S_PLAY:   if (r_life == '0 || r_score == SW'(SCORE_MAX)) w_state_nx = S_FINISH;
                else if (w_pause_rise) w_state_nx = S_PAUSE;
      S_PAUSE:  if (w_pause_rise) w_state_nx = S_PLAY;
      S_FINISH: if (w_start_rise) w_state_nx = S_IDLE;
      default:  w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_start_d <= 1'b0;
      r_pause_d <= 1'b0;
      r_life    <= LW'(LIFE_MAX);
      r_score   <= '0;
      r_level   <= '0;
      r_lfsr    <= LFSR_SEED;
      r_timer   <= '0;
      r_period  <= period_of('0);
      r_fire    <= FIRE_INIT;
      r_gold    <= '0;
      r_hit     <= '0;
      r_caught  <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_start_d <= i_start;
      r_pause_d <= i_pause;
      if (w_to_idle) begin
        r_life   <= LW'(LIFE_MAX);
        r_score  <= '0;
        r_level  <= '0;
        r_lfsr   <= LFSR_SEED;
        r_timer  <= '0;
        r_period <= period_of('0);
        r_fire   <= FIRE_INIT;
        r_gold   <= '0;
        r_hit    <= '0;
        r_caught <= 1'b0;
      end else if (w_play) begin
        // damage uses the pre-step pattern; a step's clear of hit/caught wins
        if (!i_super) begin
          r_life <= (int'(w_d) >= int'(r_life)) ? '0 : r_life - LW'(w_d);
          r_hit  <= r_hit | w_dmg;
        end
        if (w_catch) begin
          r_caught <= 1'b1;
          if (r_score != SW'(SCORE_MAX)) r_score <= r_score + SW'(1);
          if (r_level != VW'(LEVEL_MAX)) r_level <= r_level + VW'(1);
        end
        if (w_step) begin
          r_timer  <= '0;
          r_period <= period_of(r_level);
          r_lfsr   <= w_lfsr_nx;
          r_fire   <= w_fire_nx;
          r_gold   <= w_gold_nx;
          r_hit    <= '0;
          r_caught <= 1'b0;
        end else begin
          r_timer  <= r_timer + TW'(1);
        end
      end
    end
  end

  assign o_game_state = r_state;
  assign o_fire_state = r_fire & ~r_hit;
  assign o_gold_state = w_gold_vis;
  assign o_hit_bitmap = r_hit;
  assign o_life       = r_life;
  assign o_score      = r_score;
  assign o_level      = r_level;
  assign o_step_pulse = w_step;
  assign o_win        = (r_state == S_FINISH) && (r_score == SW'(SCORE_MAX)) && (r_life != '0);
endmodule

// File: tb/tb_fire_gold_game_ctrl_param.sv
// Bench for fire_gold_game_ctrl_param: a driver applies stimulus, advances a
// behavioural game model and queues the outputs the model predicts for that
// cycle; a negedge monitor pops each entry and compares it to the DUT.
module tb_fire_gold_game_ctrl_param;
  localparam int CELLS = 9, LIFE_MAX = 5, SCORE_MAX = 3, FIRE_MAX = 4;
  localparam int BASE = 8, MINP = 2, LEVEL_MAX = 3;
  localparam int ALL = (1 << CELLS) - 1;
  localparam int M_IDLE = 0, M_PLAY = 1, M_FINISH = 2, M_PAUSE = 3;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, pause = 1'b0, sup = 1'b0;
  logic [8:0] box = '0;
  logic [1:0] o_game_state;
  logic [8:0] o_fire_state, o_gold_state, o_hit_bitmap;
  logic [2:0] o_life;
  logic [1:0] o_score, o_level;
  logic       o_step_pulse, o_win;

  fire_gold_game_ctrl_param #(
    .CELLS(CELLS), .LIFE_MAX(LIFE_MAX), .SCORE_MAX(SCORE_MAX), .FIRE_MAX(FIRE_MAX),
    .BASE_PERIOD(BASE), .MIN_PERIOD(MINP), .LEVEL_MAX(LEVEL_MAX),
    .LFSR_SEED(16'hACE1), .FIRE_INIT(9'b101000100)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_pause(pause), .i_super(sup), .i_box(box),
    .o_game_state(o_game_state), .o_fire_state(o_fire_state), .o_gold_state(o_gold_state),
    .o_hit_bitmap(o_hit_bitmap), .o_life(o_life), .o_score(o_score), .o_level(o_level),
    .o_step_pulse(o_step_pulse), .o_win(o_win)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] gs;
    logic [8:0] fire, gold, hit;
    logic [2:0] life;
    logic [1:0] score, level;
    logic       step, win;
  } exp_t;
  exp_t q[$];

  int n_total = 0, n_bad = 0;

  // game model: cells as int bitmasks, gold as a cell index (-1 = none)
  int m_state, m_life, m_score, m_level, m_lfsr, m_timer, m_period;
  int m_fire, m_gold, m_hit, m_caught, m_ps, m_pp;

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  function automatic int popc(input int v);
    int c = 0;
    for (int i = 0; i < CELLS; i++) c += (v >> i) & 1;
    return c;
  endfunction

  function automatic int gold_vis();
    return (m_gold >= 0 && m_caught == 0) ? (1 << m_gold) : 0;
  endfunction

  task automatic model_idle();
    m_state = M_IDLE; m_life = LIFE_MAX; m_score = 0; m_level = 0; m_lfsr = 'hACE1;
    m_timer = 0; m_period = BASE; m_fire = 'b101000100; m_gold = -1; m_hit = 0; m_caught = 0;
  endtask

  task automatic model_reset();
    model_idle();
    m_ps = 0; m_pp = 0;
  endtask

  task automatic model_step(input int st, input int pa, input int su, input int bx);
    int sr, pr, nxt, step, gv, dmg, d, lvl0, keep, c, s0, idx;
    sr = (st != 0 && m_ps == 0) ? 1 : 0;
    pr = (pa != 0 && m_pp == 0) ? 1 : 0;
    m_ps = st; m_pp = pa;
    nxt = m_state;
    case (m_state)
      M_IDLE:   if (sr != 0) nxt = M_PLAY;
      M_PAUSE:  if (pr != 0) nxt = M_PLAY;
      M_FINISH: if (sr != 0) begin model_idle(); nxt = M_IDLE; end
      default: begin
        step = (m_timer == m_period - 1) ? 1 : 0;
        gv   = gold_vis();
        dmg  = bx & m_fire & ~m_hit & ~gv & ALL;
        d    = popc(dmg);
        lvl0 = m_level;
        if (m_life == 0 || m_score == SCORE_MAX) nxt = M_FINISH;
        else if (pr != 0) nxt = M_PAUSE;
        if (su == 0) begin
          m_life = (d >= m_life) ? 0 : m_life - d;
          m_hit  = m_hit | dmg;
        end
        if ((bx & gv) != 0) begin
          m_caught = 1;
          if (m_score < SCORE_MAX) m_score++;
          if (m_level < LEVEL_MAX) m_level++;
        end
        if (step != 0) begin
          m_timer  = 0;
          m_period = ((BASE >> lvl0) < MINP) ? MINP : (BASE >> lvl0);
          m_lfsr   = (m_lfsr & 1) ? ((m_lfsr >> 1) ^ 'hB400) : (m_lfsr >> 1);
          keep = 0; c = 0;
          for (int i = 0; i < CELLS; i++)
            if (((m_lfsr >> i) & 1) != 0 && c < FIRE_MAX) begin keep |= (1 << i); c++; end
          m_fire = keep; m_hit = 0; m_caught = 0;
          if (m_gold >= 0) m_gold = -1;
          else begin
            s0 = ((m_lfsr >> 12) & 15) % CELLS;
            for (int i = CELLS - 1; i >= 0; i--) begin
              idx = (s0 + i) % CELLS;
              if (((m_fire >> idx) & 1) == 0) m_gold = idx;
            end
          end
        end else m_timer++;
      end
    endcase
    m_state = nxt;
  endtask

  task automatic push_exp();
    exp_t e;
    e.gs    = 2'(m_state);
    e.fire  = 9'(m_fire & ~m_hit);
    e.gold  = 9'(gold_vis());
    e.hit   = 9'(m_hit);
    e.life  = 3'(m_life);
    e.score = 2'(m_score);
    e.level = 2'(m_level);
    e.step  = (m_state == M_PLAY && m_timer == m_period - 1);
    e.win   = (m_state == M_FINISH && m_score == SCORE_MAX && m_life != 0);
    q.push_back(e);
  endtask

  // one clock of stimulus; called just after a rising edge
  task automatic cyc(input int st, input int pa, input int su, input int bx);
    rst = 1'b0; start = st[0]; pause = pa[0]; sup = su[0]; box = 9'(bx);
    push_exp();
    model_step(st, pa, su, bx);
    @(posedge clk); #1;
  endtask

  task automatic rst_cyc();
    rst = 1'b1;
    model_reset();
    push_exp();
    @(posedge clk); #1;
  endtask

  function automatic int low_bit(input int v);
    for (int i = 0; i < CELLS; i++) if (((v >> i) & 1) != 0) return (1 << i);
    return 0;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("game_state", int'(o_game_state), int'(e.gs));
      chk("fire_state", int'(o_fire_state), int'(e.fire));
      chk("gold_state", int'(o_gold_state), int'(e.gold));
      chk("hit_bitmap", int'(o_hit_bitmap), int'(e.hit));
      chk("life",       int'(o_life),       int'(e.life));
      chk("score",      int'(o_score),      int'(e.score));
      chk("level",      int'(o_level),      int'(e.level));
      chk("step_pulse", int'(o_step_pulse), int'(e.step));
      chk("win",        int'(o_win),        int'(e.win));
      chk("fire_pop_le_max", (popc(int'(o_fire_state)) <= FIRE_MAX) ? 1 : 0, 1);
    end
  end

  initial begin
    int n;
    model_reset();
    @(posedge clk); #1;
    rst_cyc(); rst_cyc();
    chk("reset_fire_init", int'(o_fire_state), 'b101000100);

    // 1: start, free running with super and no gold contact
    cyc(1, 0, 1, 0); cyc(0, 0, 1, 0);
    chk("t1_play", int'(o_game_state), 1);
    for (int i = 0; i < 40; i++) cyc(0, 0, 1, $urandom & ALL & ~gold_vis());

    // 2: sit on one fire cell per step until one life is left
    n = 0;
    while (m_life > 1 && n < 300) begin cyc(0, 0, 0, low_bit(m_fire)); n++; end
    chk("t2_life_one", int'(o_life), 1);

    // 3: touch every un-hit fire cell at once -> loss
    n = 0;
    while (m_state != M_FINISH && n < 300) begin cyc(0, 0, 0, m_fire & ~m_hit); n++; end
    chk("t3_finish", int'(o_game_state), 2);
    chk("t3_win", int'(o_win), 0);
    cyc(0, 0, 0, 0); cyc(1, 0, 0, 0); cyc(0, 0, 0, 0);
    chk("t3_idle", int'(o_game_state), 0);

    // 4: chase the gold until the game is won
    cyc(1, 0, 1, 0); cyc(0, 0, 1, 0);
    n = 0;
    while (m_state != M_FINISH && n < 600) begin cyc(0, 0, 1, gold_vis()); n++; end
    chk("t4_finish", int'(o_game_state), 2);
    chk("t4_win", int'(o_win), 1);
    cyc(0, 0, 1, 0); cyc(1, 0, 1, 0); cyc(0, 0, 1, 0); cyc(1, 0, 1, 0); cyc(0, 0, 1, 0);

    // 5: pause for 50 clocks mid-step, then resume
    for (int i = 0; i < 13; i++) cyc(0, 0, 1, $urandom & ALL & ~gold_vis());
    cyc(0, 1, 1, 0); cyc(0, 0, 1, 0);
    chk("t5_pause", int'(o_game_state), 3);
    for (int i = 0; i < 50; i++) cyc(0, 0, $urandom_range(0, 1), $urandom & ALL);
    cyc(0, 1, 1, 0);
    chk("t5_resume", int'(o_game_state), 1);
    for (int i = 0; i < 20; i++) cyc(0, 0, 1, $urandom & ALL & ~gold_vis());

    // 6: reach score 2 then reset mid-game
    n = 0;
    while (m_score < 2 && n < 600) begin cyc(0, 0, 1, gold_vis()); n++; end
    chk("t6_score_two", int'(o_score), 2);
    cyc(0, 0, 1, 0); cyc(0, 0, 1, 0);
    rst_cyc();
    chk("t6_rst_state", int'(o_game_state), 0);
    chk("t6_rst_fire", int'(o_fire_state), 'b101000100);
    chk("t6_rst_life", int'(o_life), LIFE_MAX);
    chk("t6_rst_score", int'(o_score), 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0);

    // random play with restarts, pauses and the odd reset
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 199) == 0) rst_cyc();
      else cyc(($urandom_range(0, 7) == 0) ? 1 : 0, ($urandom_range(0, 11) == 0) ? 1 : 0,
               $urandom_range(0, 1), (($urandom & 3) == 0) ? gold_vis() : ($urandom & ALL));
    end

    n = 0;
    while (q.size() > 0 && n < 10) begin @(posedge clk); n++; end
    chk("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
